// File: rtl/io_input_conditioner.sv
// Board-input conditioner: 2-flop synchronisers, shared-counter debounce for the switch bus and the button,
// press detector with snapshot/ack handshake. Optional sticky overrun flag under `SNAP_OVERRUN_EN.

module io_debounce #(
  parameter int W               = 16,
  parameter int DEBOUNCE_CYCLES = 230000,
  parameter int CNT_W           = 18
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1, sync2, cand;
  logic [CNT_W-1:0] cnt;

  // One counter per bus: any bit moving restarts the whole word, so a
  // partially settled bus is never accepted.
  always_ff @(posedge clock) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cand != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= cand;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 230000,
  parameter int CNT_W           = 18
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] sw_raw,
  input  logic        btn_raw,
  input  logic        rd_ack,
  output logic [15:0] sw_stable,
  output logic        btn_level,
  output logic        btn_pulse,
  output logic [15:0] sw_snapshot,
  output logic        snap_valid,
  output logic        overrun
);
  localparam logic IDLE    = 1'b0;
  localparam logic PRESSED = 1'b1;

  logic state;
  logic btn_prev;
  logic capture;

  io_debounce #(.W(16), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw_db (
    .clock  (clock),
    .rst    (rst),
    .raw    (sw_raw),
    .stable (sw_stable)
  );

  io_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn_db (
    .clock  (clock),
    .rst    (rst),
    .raw    (btn_raw),
    .stable (btn_level)
  );

  // Only a fresh rising level in IDLE counts; holding the button stays in PRESSED.
  assign capture   = (state == IDLE) && btn_level && !btn_prev;
  assign btn_pulse = capture;

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_level;
      case (state)
        IDLE:    if (capture)    state <= PRESSED;
        PRESSED: if (!btn_level) state <= IDLE;
        default:                 state <= IDLE;
      endcase
    end
  end

  // Capture beats a same-cycle ack: the new value is pending after the edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      sw_snapshot <= '0;
      snap_valid  <= 1'b0;
    end else if (capture) begin
      sw_snapshot <= sw_stable;
      snap_valid  <= 1'b1;
    end else if (rd_ack && snap_valid) begin
      snap_valid  <= 1'b0;
    end
  end

`ifdef SNAP_OVERRUN_EN
  always_ff @(posedge clock) begin
    if (rst)
      overrun <= 1'b0;
    else if (rd_ack && overrun)
      overrun <= 1'b0;
    else if (capture && snap_valid && !rd_ack)
      overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner (DEBOUNCE_CYCLES=4): stimulus pushes expected
// sw_stable changes and button captures; monitors pop and compare when the DUT shows them.

module tb_io_input_conditioner;
  localparam int DEB = 4;
  // Input driven after edge c reaches the debounced output at edge c+3+DEB.
  localparam int LAT = DEB + 3;
`ifdef SNAP_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_raw = '0;
  logic        btn_raw = 1'b0;
  logic        rd_ack = 1'b0;
  logic [15:0] sw_stable, sw_snapshot;
  logic        btn_level, btn_pulse, snap_valid, overrun;

  io_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clock       (clock),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .btn_raw     (btn_raw),
    .rd_ack      (rd_ack),
    .sw_stable   (sw_stable),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .sw_snapshot (sw_snapshot),
    .snap_valid  (snap_valid),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t sw_q[$];
  exp_t snap_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // sw_stable monitor: every change must match the next expected value and edge.
  initial begin
    logic [15:0] prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clock);
      if (mon_en && sw_stable !== prev) begin
        if (sw_q.size() == 0) begin
          chk("sw_stable_unexpected", 32'(sw_stable), 32'(prev));
        end else begin
          e = sw_q.pop_front();
          chk("sw_stable_val", 32'(sw_stable), 32'(e.val));
          chk("sw_stable_cycle", cyc, e.cyc);
        end
        prev = sw_stable;
      end
    end
  end

  // Press monitor: each btn_pulse must be expected; the following cycle must show the snapshot.
  initial begin
    exp_t        e;
    logic [15:0] pend_val;
    bit          pend;
    pend = 1'b0;
    pend_val = '0;
    forever begin
      @(negedge clock);
      if (pend) begin
        chk("snapshot_loaded", 32'(sw_snapshot), 32'(pend_val));
        chk("snap_valid_set", 32'(snap_valid), 32'd1);
        pend = 1'b0;
      end
      if (mon_en && btn_pulse === 1'b1) begin
        if (snap_q.size() == 0) begin
          chk("btn_pulse_unexpected", 32'(btn_pulse), 32'd0);
        end else begin
          e = snap_q.pop_front();
          chk("btn_pulse_cycle", cyc, e.cyc);
          chk("capture_value", 32'(sw_stable), 32'(e.val));
          pend = 1'b1;
          pend_val = e.val;
        end
      end
    end
  end

  task automatic set_sw(input logic [15:0] v);
    exp_t e;
    sw_raw = v;
    e.val = v;
    e.cyc = cyc + LAT;
    sw_q.push_back(e);
    repeat (LAT + 2) tick();
  endtask

  task automatic press(input logic [15:0] v);
    exp_t e;
    btn_raw = 1'b1;
    e.val = v;
    e.cyc = cyc + LAT;
    snap_q.push_back(e);
    repeat (LAT + 3) tick();
  endtask

  task automatic release_btn();
    btn_raw = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sw_stable"}, 32'(sw_stable), 32'd0);
    chk({tag, "_btn_level"}, 32'(btn_level), 32'd0);
    chk({tag, "_btn_pulse"}, 32'(btn_pulse), 32'd0);
    chk({tag, "_sw_snapshot"}, 32'(sw_snapshot), 32'd0);
    chk({tag, "_snap_valid"}, 32'(snap_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    exp_t e;

    // 1: reset with switches high, then release and hold
    sw_raw = 16'hFFFF;
    rst = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    e.val = 16'hFFFF;
    e.cyc = cyc + LAT;
    sw_q.push_back(e);
    repeat (LAT + 2) tick();
    chk("sw_after_reset", 32'(sw_stable), 32'h0000FFFF);

    // 2: bit0 glitch for 2 cycles while 00A5 is debouncing
    sw_raw = 16'h00A5;
    repeat (3) tick();
    sw_raw = 16'h00A4;
    repeat (2) tick();
    chk("sw_held_during_glitch", 32'(sw_stable), 32'h0000FFFF);
    set_sw(16'h00A5);
    chk("sw_after_glitch", 32'(sw_stable), 32'h000000A5);

    // 3: bouncing press, then held: one pulse, snapshot 1234
    set_sw(16'h1234);
    btn_raw = 1'b1;
    tick();
    btn_raw = 1'b0;
    tick();
    btn_raw = 1'b1;
    e.val = 16'h1234;
    e.cyc = cyc + LAT;
    snap_q.push_back(e);
    repeat (12) tick();
    chk("t3_btn_level", 32'(btn_level), 32'd1);
    chk("t3_snapshot", 32'(sw_snapshot), 32'h00001234);
    chk("t3_snap_valid", 32'(snap_valid), 32'd1);
    chk("t3_overrun", 32'(overrun), 32'd0);

    // 4: ack clears, second ack is ignored
    ack();
    chk("t4_ack_clears", 32'(snap_valid), 32'd0);
    ack();
    chk("t4_ack_ignored", 32'(snap_valid), 32'd0);
    chk("t4_snapshot_kept", 32'(sw_snapshot), 32'h00001234);

    // 5: two presses without ack -> overwrite (and overrun when enabled)
    release_btn();
    chk("t5_btn_released", 32'(btn_level), 32'd0);
    set_sw(16'h1111);
    press(16'h1111);
    chk("t5_first_no_overrun", 32'(overrun), 32'd0);
    release_btn();
    set_sw(16'h5678);
    press(16'h5678);
    chk("t5_snapshot", 32'(sw_snapshot), 32'h00005678);
    chk("t5_snap_valid", 32'(snap_valid), 32'd1);
    chk("t5_overrun", 32'(overrun), 32'(EXP_OVR));
    ack();
    chk("t5_ack_valid", 32'(snap_valid), 32'd0);
    chk("t5_ack_overrun", 32'(overrun), 32'd0);

    // 6: capture in the same cycle as rd_ack -> capture wins
    release_btn();
    press(16'h5678);
    release_btn();
    set_sw(16'h9ABC);
    btn_raw = 1'b1;
    e.val = 16'h9ABC;
    e.cyc = cyc + LAT;
    snap_q.push_back(e);
    repeat (LAT) tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    chk("t6_coincide_valid", 32'(snap_valid), 32'd1);
    chk("t6_coincide_snapshot", 32'(sw_snapshot), 32'h00009ABC);
    chk("t6_coincide_overrun", 32'(overrun), 32'd0);
    repeat (3) tick();

    // 6b: reset in the middle of a switch debounce
    release_btn();
    sw_raw = 16'h0F0F;
    repeat (4) tick();
    rst = 1'b1;
    e.val = 16'h0000;
    e.cyc = cyc + 1;
    sw_q.push_back(e);
    repeat (2) tick();
    chk_all_zero("midreset");
    rst = 1'b0;
    e.val = 16'h0F0F;
    e.cyc = cyc + LAT;
    sw_q.push_back(e);
    repeat (LAT + 2) tick();
    press(16'h0F0F);
    chk("t6_idle_after_reset", 32'(snap_valid), 32'd1);
    release_btn();

    for (int i = 0; i < 40 && (sw_q.size() != 0 || snap_q.size() != 0); i++) tick();
    chk("sw_queue_drained", sw_q.size(), 32'd0);
    chk("pulse_queue_drained", snap_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
